// File: rtl/mc_ctrl_defs.sv
// Shared definitions for the multi-cycle controller: state codes, opcode and
// funct constants, ALU operation codes and datapath mux select codes.
package mc_ctrl_defs;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_LUI = 4'd5;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Dispatch out of DECODE: opcode class selects the first execute state;
    // anything unrecognised (including a bad R-type funct) goes to TRAP.
    function automatic state_t decode_next(input logic [5:0] op, input logic r_illegal);
        state_t ns;
        case (op)
            OP_RTYPE:               ns = r_illegal ? S_TRAP : S_R_EXEC;
            OP_LW, OP_SW:           ns = S_MEM_ADDR;
            OP_BEQ:                 ns = S_BRANCH;
            OP_J:                   ns = S_JUMP;
            OP_ADDIU, OP_ORI, OP_LUI: ns = S_I_EXEC;
            default:                ns = S_TRAP;
        endcase
        return ns;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct decoder: maps funct to the ALU operation code and flags any
// funct the controller does not implement.
import mc_ctrl_defs::*;

module mc_alu_dec (
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       r_illegal
);

    // Pure lookup; unknown funct falls back to ADD with the illegal flag set.
    always_comb begin
        alu_ctrl  = ALU_ADD;
        r_illegal = 1'b0;
        case (funct)
            FN_ADDU: alu_ctrl = ALU_ADD;
            FN_SUBU: alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: r_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the shared PC/IM/GPR/ALU datapath.
// Optional build macro MC_CTRL_ILLEGAL_TRAP_EN: when defined, an illegal
// instruction parks the FSM in TRAP with the 'illegal' output raised until
// reset; when undefined, TRAP is a one-cycle NOP that retires and refetches.
import mc_ctrl_defs::*;

module mc_ctrl #(
    // Must stay at the FETCH code; other values would start mid-instruction.
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic [3:0] alu_ctrl,
    output logic [1:0] pc_source,
    output logic       retire,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic [3:0] state_o
);

    state_t     state;
    state_t     next_state;
    logic [3:0] r_alu_ctrl;
    logic       r_illegal;

    mc_alu_dec u_alu_dec (
        .funct     (funct),
        .alu_ctrl  (r_alu_ctrl),
        .r_illegal (r_illegal)
    );

    assign state_o = state;

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= state_t'(RESET_STATE);
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath controls; all outputs are forced low while
    // reset is asserted so an abandoned instruction cannot write or retire.
    always_comb begin
        next_state    = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        ext_op        = 1'b0;
        alu_ctrl      = ALU_ADD;
        pc_source     = PCSRC_ALU;
        retire        = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        illegal       = 1'b0;
`endif

        case (state)
            S_FETCH: begin
                // PC+4 computed while the instruction is read; IR and PC
                // only latch in the cycle the memory completes.
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                alu_src_b  = SRCB_IMM_SH2;
                ext_op     = 1'b1;
                next_state = decode_next(opcode, r_illegal);
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                ext_op     = 1'b1;
                next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retire    = mem_ready;
                if (mem_ready) next_state = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = r_alu_ctrl;
                next_state = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_ctrl      = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                retire        = 1'b1;
                next_state    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                next_state = S_I_WB;
                case (opcode)
                    OP_ORI:  alu_ctrl = ALU_OR;
                    OP_LUI:  alu_ctrl = ALU_LUI;
                    default: begin
                        ext_op   = 1'b1;
                        alu_ctrl = ALU_ADD;
                    end
                endcase
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_TRAP: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                illegal    = 1'b1;
                next_state = S_TRAP;
`else
                retire     = 1'b1;
                next_state = S_FETCH;
`endif
            end
            default: next_state = S_FETCH;
        endcase

        if (!reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            i_or_d        = 1'b0;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = SRCB_REG;
            ext_op        = 1'b0;
            alu_ctrl      = ALU_ADD;
            pc_source     = PCSRC_ALU;
            retire        = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            illegal       = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: a per-cycle vector table of inputs and
// hand-derived expected state/outputs, plus trap and mid-write reset sequences.
module tb_mc_ctrl;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a, ext_op, retire;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_ctrl, state_o;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int n_vec = 0;
    int n_bad = 0;

    mc_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .ext_op        (ext_op),
        .alu_ctrl      (alu_ctrl),
        .pc_source     (pc_source),
        .retire        (retire),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        .illegal       (illegal),
`endif
        .state_o       (state_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        logic [3:0] st;
        logic [19:0] out;
    } vec_t;

    vec_t tbl[$];

    // Output word order: pcw,pcc,irw,mr,mw,iod,rw,rd,m2r,asa,asb[1:0],ext,alu[3:0],pcs[1:0],ret
    function automatic logic [19:0] pk(int pcw, int pcc, int irw, int mr, int mw, int iod,
                                       int rw, int rd, int m2r, int asa, int asb, int ext,
                                       int alu, int pcs, int ret);
        return {pcw[0], pcc[0], irw[0], mr[0], mw[0], iod[0], rw[0], rd[0], m2r[0],
                asa[0], asb[1:0], ext[0], alu[3:0], pcs[1:0], ret[0]};
    endfunction

    function automatic logic [19:0] e_fetch(int rdy);
        return pk(rdy,0,rdy,1,0,0, 0,0,0,0,1,0, 0,0,0);
    endfunction
    function automatic logic [19:0] e_dec();
        return pk(0,0,0,0,0,0, 0,0,0,0,3,1, 0,0,0);
    endfunction
    function automatic logic [19:0] e_maddr();
        return pk(0,0,0,0,0,0, 0,0,0,1,2,1, 0,0,0);
    endfunction
    function automatic logic [19:0] e_mrd();
        return pk(0,0,0,1,0,1, 0,0,0,0,0,0, 0,0,0);
    endfunction
    function automatic logic [19:0] e_mwb();
        return pk(0,0,0,0,0,0, 1,0,1,0,0,0, 0,0,1);
    endfunction
    function automatic logic [19:0] e_mwr(int rdy);
        return pk(0,0,0,0,1,1, 0,0,0,0,0,0, 0,0,rdy);
    endfunction
    function automatic logic [19:0] e_rex(int alu);
        return pk(0,0,0,0,0,0, 0,0,0,1,0,0, alu,0,0);
    endfunction
    function automatic logic [19:0] e_rwb();
        return pk(0,0,0,0,0,0, 1,1,0,0,0,0, 0,0,1);
    endfunction
    function automatic logic [19:0] e_br();
        return pk(0,1,0,0,0,0, 0,0,0,1,0,0, 1,1,1);
    endfunction
    function automatic logic [19:0] e_j();
        return pk(1,0,0,0,0,0, 0,0,0,0,0,0, 0,2,1);
    endfunction
    function automatic logic [19:0] e_iex(int ext, int alu);
        return pk(0,0,0,0,0,0, 0,0,0,1,2,ext, alu,0,0);
    endfunction
    function automatic logic [19:0] e_iwb();
        return pk(0,0,0,0,0,0, 1,0,0,0,0,0, 0,0,1);
    endfunction

    function automatic vec_t mk(int rst_n, int op, int fn, int z, int rdy, int st, logic [19:0] out);
        vec_t v;
        v.rst_n = rst_n[0];
        v.op    = op[5:0];
        v.fn    = fn[5:0];
        v.z     = z[0];
        v.rdy   = rdy[0];
        v.st    = st[3:0];
        v.out   = out;
        return v;
    endfunction

    // Drive one cycle's inputs after the falling edge, compare before the
    // next rising edge, then move to the following falling edge.
    task automatic run_cycle(input string name, input vec_t v, input logic exp_ill);
        logic [19:0] act;
        reset     = v.rst_n;
        opcode    = v.op;
        funct     = v.fn;
        zero      = v.z;
        mem_ready = v.rdy;
        #1;
        act = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op,
               alu_ctrl, pc_source, retire};
        n_vec++;
        if (state_o !== v.st || act !== v.out) begin
            n_bad++;
            $display("FAIL %s: state=%0d outputs=%05h, required state=%0d outputs=%05h",
                     name, state_o, act, v.st, v.out);
        end
        if (mem_read === 1'b1 && mem_write === 1'b1) begin
            n_bad++;
            $display("FAIL %s: mem_read and mem_write both high", name);
        end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        n_vec++;
        if (illegal !== exp_ill) begin
            n_bad++;
            $display("FAIL %s_illegal: illegal=%b, required %b", name, illegal, exp_ill);
        end
`else
        if (exp_ill) begin end
`endif
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);

        // reset held low two cycles
        tbl.push_back(mk(0, 6'h00, 6'h21, 0, 1, 0, 20'd0));
        tbl.push_back(mk(0, 6'h00, 6'h21, 0, 1, 0, 20'd0));
        // addu: 0,1,6,7
        tbl.push_back(mk(1, 6'h00, 6'h21, 0, 1, 0, e_fetch(1)));
        tbl.push_back(mk(1, 6'h00, 6'h21, 0, 1, 1, e_dec()));
        tbl.push_back(mk(1, 6'h00, 6'h21, 0, 1, 6, e_rex(0)));
        tbl.push_back(mk(1, 6'h00, 6'h21, 0, 1, 7, e_rwb()));
        // subu, with mem_ready low outside FETCH (must be ignored)
        tbl.push_back(mk(1, 6'h00, 6'h23, 0, 1, 0, e_fetch(1)));
        tbl.push_back(mk(1, 6'h00, 6'h23, 0, 0, 1, e_dec()));
        tbl.push_back(mk(1, 6'h00, 6'h23, 0, 0, 6, e_rex(1)));
        tbl.push_back(mk(1, 6'h00, 6'h23, 0, 0, 7, e_rwb()));
        // and / or / slt execute codes
        tbl.push_back(mk(1, 6'h00, 6'h24, 0, 1, 0, e_fetch(1)));
        tbl.push_back(mk(1, 6'h00, 6'h24, 0, 1, 1, e_dec()));
        tbl.push_back(mk(1, 6'h00, 6'h24, 0, 1, 6, e_rex(2)));
        tbl.push_back(mk(1, 6'h00, 6'h24, 0, 1, 7, e_rwb()));
        tbl.push_back(mk(1, 6'h00, 6'h25, 0, 1, 0, e_fetch(1)));
        tbl.push_back(mk(1, 6'h00, 6'h25, 0, 1, 1, e_dec()));
        tbl.push_back(mk(1, 6'h00, 6'h25, 0, 1, 6, e_rex(3)));
        tbl.push_back(mk(1, 6'h00, 6'h25, 0, 1, 7, e_rwb()));
        tbl.push_back(mk(1, 6'h00, 6'h2A, 0, 1, 0, e_fetch(1)));
        tbl.push_back(mk(1, 6'h00, 6'h2A, 0, 1, 1, e_dec()));
        tbl.push_back(mk(1, 6'h00, 6'h2A, 0, 1, 6, e_rex(4)));
        tbl.push_back(mk(1, 6'h00, 6'h2A, 0, 1, 7, e_rwb()));
        // lw: one fetch wait state, two read wait states: 0,0,1,2,3,3,3,4
        tbl.push_back(mk(1, 6'h23, 6'h00, 0, 0, 0, e_fetch(0)));
        tbl.push_back(mk(1, 6'h23, 6'h00, 0, 1, 0, e_fetch(1)));
        tbl.push_back(mk(1, 6'h23, 6'h00, 0, 1, 1, e_dec()));
        tbl.push_back(mk(1, 6'h23, 6'h00, 0, 1, 2, e_maddr()));
        tbl.push_back(mk(1, 6'h23, 6'h00, 0, 0, 3, e_mrd()));
        tbl.push_back(mk(1, 6'h23, 6'h00, 0, 0, 3, e_mrd()));
        tbl.push_back(mk(1, 6'h23, 6'h00, 0, 1, 3, e_mrd()));
        tbl.push_back(mk(1, 6'h23, 6'h00, 0, 0, 4, e_mwb()));
        // sw with one write wait state
        tbl.push_back(mk(1, 6'h2B, 6'h00, 0, 1, 0, e_fetch(1)));
        tbl.push_back(mk(1, 6'h2B, 6'h00, 0, 1, 1, e_dec()));
        tbl.push_back(mk(1, 6'h2B, 6'h00, 0, 1, 2, e_maddr()));
        tbl.push_back(mk(1, 6'h2B, 6'h00, 0, 0, 5, e_mwr(0)));
        tbl.push_back(mk(1, 6'h2B, 6'h00, 0, 1, 5, e_mwr(1)));
        // beq taken, then not taken
        tbl.push_back(mk(1, 6'h04, 6'h00, 1, 1, 0, e_fetch(1)));
        tbl.push_back(mk(1, 6'h04, 6'h00, 1, 1, 1, e_dec()));
        tbl.push_back(mk(1, 6'h04, 6'h00, 1, 1, 8, e_br()));
        tbl.push_back(mk(1, 6'h04, 6'h00, 0, 1, 0, e_fetch(1)));
        tbl.push_back(mk(1, 6'h04, 6'h00, 0, 1, 1, e_dec()));
        tbl.push_back(mk(1, 6'h04, 6'h00, 0, 1, 8, e_br()));
        // j
        tbl.push_back(mk(1, 6'h02, 6'h00, 0, 1, 0, e_fetch(1)));
        tbl.push_back(mk(1, 6'h02, 6'h00, 0, 1, 1, e_dec()));
        tbl.push_back(mk(1, 6'h02, 6'h00, 0, 1, 9, e_j()));
        // addiu / ori / lui
        tbl.push_back(mk(1, 6'h09, 6'h00, 0, 1, 0, e_fetch(1)));
        tbl.push_back(mk(1, 6'h09, 6'h00, 0, 1, 1, e_dec()));
        tbl.push_back(mk(1, 6'h09, 6'h00, 0, 1, 10, e_iex(1, 0)));
        tbl.push_back(mk(1, 6'h09, 6'h00, 0, 1, 11, e_iwb()));
        tbl.push_back(mk(1, 6'h0D, 6'h00, 0, 1, 0, e_fetch(1)));
        tbl.push_back(mk(1, 6'h0D, 6'h00, 0, 1, 1, e_dec()));
        tbl.push_back(mk(1, 6'h0D, 6'h00, 0, 1, 10, e_iex(0, 3)));
        tbl.push_back(mk(1, 6'h0D, 6'h00, 0, 1, 11, e_iwb()));
        tbl.push_back(mk(1, 6'h0F, 6'h00, 0, 1, 0, e_fetch(1)));
        tbl.push_back(mk(1, 6'h0F, 6'h00, 0, 1, 1, e_dec()));
        tbl.push_back(mk(1, 6'h0F, 6'h00, 0, 1, 10, e_iex(0, 5)));
        tbl.push_back(mk(1, 6'h0F, 6'h00, 0, 1, 11, e_iwb()));

        for (int i = 0; i < tbl.size(); i++) begin
            run_cycle($sformatf("vec%0d", i), tbl[i], 1'b0);
        end

        // Illegal opcode 0x3F, then illegal R-type funct 0x3F
        for (int k = 0; k < 2; k++) begin
            logic [5:0] op_t;
            op_t = (k == 0) ? 6'h3F : 6'h00;
            run_cycle("trap_fetch", mk(1, op_t, 6'h3F, 0, 1, 0, e_fetch(1)), 1'b0);
            run_cycle("trap_decode", mk(1, op_t, 6'h3F, 0, 1, 1, e_dec()), 1'b0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            for (int c = 0; c < 11; c++) begin
                run_cycle("trap_hold", mk(1, op_t, 6'h3F, 0, 1, 12, 20'd0), 1'b1);
            end
            run_cycle("trap_reset", mk(0, 6'h00, 6'h21, 0, 1, 12, 20'd0), 1'b0);
`else
            run_cycle("trap_nop", mk(1, op_t, 6'h3F, 0, 1, 12, pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1)), 1'b0);
`endif
            run_cycle("trap_exit", mk(1, 6'h00, 6'h21, 0, 0, 0, e_fetch(0)), 1'b0);
        end

        // Reset asserted during a stalled sw: outputs drop at once, no retire,
        // and the next state is FETCH.
        run_cycle("rst_sw_fetch", mk(1, 6'h2B, 6'h00, 0, 1, 0, e_fetch(1)), 1'b0);
        run_cycle("rst_sw_decode", mk(1, 6'h2B, 6'h00, 0, 1, 1, e_dec()), 1'b0);
        run_cycle("rst_sw_addr", mk(1, 6'h2B, 6'h00, 0, 1, 2, e_maddr()), 1'b0);
        run_cycle("rst_sw_wait", mk(1, 6'h2B, 6'h00, 0, 0, 5, e_mwr(0)), 1'b0);
        run_cycle("rst_sw_abort", mk(0, 6'h2B, 6'h00, 0, 0, 5, 20'd0), 1'b0);
        run_cycle("rst_sw_after", mk(1, 6'h2B, 6'h00, 0, 0, 0, e_fetch(0)), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control FSM that sequences the shared PC/IM/GPR/ALU datapath so that one ALU and one memory port serve fetch, address calculation and execute across successive cycles. It decodes opcode/funct from the instruction register and drives every datapath enable and mux select. Memory accesses use a ready handshake, so instruction and data memories may insert wait states.

Parameters:
- RESET_STATE, 4'd0, state entered on reset; must encode FETCH.

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset; sampled on rising clock edge
- opcode  in  6  instruction[31:26] from the instruction register
- funct  in  6  instruction[5:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read or write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by zero (beq)
- ir_write  out  1  instruction register load
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- reg_write  out  1  GPR write enable
- reg_dst  out  1  write register select: 0=rt, 1=rd
- mem_to_reg  out  1  GPR write data select: 0=ALUOut, 1=MDR
- alu_src_a  out  1  ALU A select: 0=PC, 1=A register
- alu_src_b  out  2  ALU B select: 0=B register, 1=constant 4, 2=ext(imm), 3=ext(imm)<<2
- ext_op  out  1  immediate extension: 0=zero-extend, 1=sign-extend
- alu_ctrl  out  4  ALU operation: 0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT, 5=LUI
- pc_source  out  2  next-PC select: 0=ALU result, 1=ALUOut, 2=jump target {pc[31:28],instr[25:0],2'b00}
- retire  out  1  one-cycle pulse in the last cycle of each instruction
- state_o  out  4  current state, for debug

Behaviour:
- Supported opcodes:
  - R-type 0x00: addu 0x21, subu 0x23, and 0x24, or 0x25, slt 0x2A
  - lw 0x23, sw 0x2B, beq 0x04, j 0x02, addiu 0x09, ori 0x0D, lui 0x0F
  - Any other opcode, or any other funct with opcode 0x00, is illegal.
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, TRAP 12.
- Reset: when reset is 0 at a clock edge, state becomes FETCH. While reset is 0, every output except state_o is forced to 0 combinationally. A reset mid-instruction abandons it: no write, no retire.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, ADD, pc_source=0.
  - ir_write and pc_write are asserted only when mem_ready=1 (Mealy). Go to DECODE on mem_ready, otherwise hold.
- DECODE: alu_src_a=0, alu_src_b=3, ext_op=1, ADD (branch target into ALUOut). Next state by opcode:
  - lw/sw -> MEM_ADDR; R-type -> R_EXEC; beq -> BRANCH; j -> JUMP
  - addiu/ori/lui -> I_EXEC; illegal -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ext_op=1, ADD. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, retire=1. Next: FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready.
  - retire is asserted in the mem_ready cycle; then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_ctrl decoded from funct. Next: R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_write_cond=1, pc_source=1, retire=1. Next: FETCH.
- JUMP: pc_write=1, pc_source=2, retire=1. Next: FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2. Next: I_WB.
  - addiu: ext_op=1, ADD; ori: ext_op=0, OR; lui: ext_op=0, LUI.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, retire=1. Next: FETCH.
- Latency, zero wait states: R/I-type 4 cycles, lw 5, sw 4, beq 3, j 3. Each wait state adds 1 cycle.
- mem_read and mem_write are never asserted together.
- mem_ready is ignored in every state except FETCH, MEM_RD and MEM_WR.
- Any output not listed for the current state is 0.

Optional Feature:
- Macro MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: adds output illegal (1 bit). TRAP asserts illegal=1, drives all other outputs to 0, and holds until reset.
- Undefined: TRAP lasts one cycle with retire=1 and no writes (illegal instruction executes as a NOP), then FETCH; the illegal port is absent.

Decomposition:
- Shared include/package mc_ctrl_defs:
  - state codes, opcode and funct constants
  - alu_ctrl codes, alu_src_b and pc_source select codes
- One sub-module, mc_alu_dec: combinational funct -> alu_ctrl map plus an r_illegal flag. Instantiated once inside mc_ctrl.

Test Plan:
- Reset low 2 cycles, then high, mem_ready=1: state_o=0, all outputs 0 during reset; first cycle after release mem_read=1, pc_write=1, ir_write=1.
- addu (opcode 0, funct 0x21), mem_ready=1: states 0,1,6,7; alu_ctrl=0 in R_EXEC; reg_write=1, reg_dst=1 and retire=1 on cycle 4.
- lw with mem_ready low 2 cycles in MEM_RD: states 0,1,2,3,3,3,4; mem_read=1, i_or_d=1 throughout MEM_RD; reg_write with mem_to_reg=1 in state 4.
- beq with zero=1, then beq with zero=0: both 3 cycles; pc_write_cond=1, pc_source=1, alu_ctrl=1 in BRANCH; pc_write=0.
- Opcode 0x3F: with the macro, state 12 holds and illegal=1 for 10+ cycles. Without it, one TRAP cycle with retire=1, then state 0.
- reset=0 during MEM_WR with mem_ready=0: next state is 0, mem_write drops immediately, no retire pulse.
